// File: rtl/enemy_plotter_pkg.sv
// Shared constants and state encoding for the enemy sprite plotter.
package enemy_plotter_pkg;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PLOT,
        ST_DONE
    } state_e;

    function automatic logic op_is_valid(input logic [1:0] op);
        return (op == OP_DRAW) || (op == OP_ERASE);
    endfunction

endpackage

// File: rtl/enemy_plotter_if.sv
// Controller <-> plotter bundle: snapshot buses, start/op, and pixel stream to the VGA adapter.
interface enemy_plotter_if #(
    parameter int unsigned N_PLANES = 10
);
    logic                    load_coord;
    logic                    datapath_en;
    logic [1:0]              op;
    logic [8*N_PLANES-1:0]   x_bus;
    logic [8*N_PLANES-1:0]   y_bus;
    logic [3*N_PLANES-1:0]   vis_bus;
    logic [7:0]              x_out;
    logic [6:0]              y_out;
    logic [2:0]              colour;
    logic                    plot;
    logic                    busy;
    logic                    done;

    modport master (
        output load_coord, datapath_en, op, x_bus, y_bus, vis_bus,
        input  x_out, y_out, colour, plot, busy, done
    );

    modport slave (
        input  load_coord, datapath_en, op, x_bus, y_bus, vis_bus,
        output x_out, y_out, colour, plot, busy, done
    );
endinterface

// File: rtl/enemy_plotter_sprite_pixel_counter.sv
// Column-fastest pixel counter over one SPR_W x SPR_H sprite; wraps to 0 after the last pixel.
module sprite_pixel_counter #(
    parameter int unsigned SPR_W = 4,
    parameter int unsigned SPR_H = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear_i,
    input  logic                     en_i,
    output logic [$clog2(SPR_W)-1:0] col_o,
    output logic [$clog2(SPR_H)-1:0] row_o,
    output logic                     last_o
);
    logic [$clog2(SPR_W)-1:0] col_q, col_d;
    logic [$clog2(SPR_H)-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            col_d = col_q + 1'b1;
            if (col_q == '1) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == '1) && (row_q == '1);
endmodule

// File: rtl/enemy_plotter.sv
// Snapshots enemy plane positions/colours and streams each visible sprite as one pixel per cycle.
module enemy_plotter
    import enemy_plotter_pkg::*;
#(
    parameter int unsigned N_PLANES = 10,
    parameter int unsigned SPR_W    = 4,
    parameter int unsigned SPR_H    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    enemy_plotter_if.slave  bus
);
    localparam int unsigned IW = $clog2(N_PLANES);
    localparam int unsigned CW = $clog2(SPR_W);
    localparam int unsigned RW = $clog2(SPR_H);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PLANES - 1);
    localparam logic [8:0]    X_LIM    = 9'(SCR_W);
    localparam logic [8:0]    Y_LIM    = 9'(SCR_H);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [1:0]              op_q, op_d;
    logic [8*N_PLANES-1:0]   x_q, y_q;
    logic [3*N_PLANES-1:0]   vis_q;

    logic                    cnt_clr, cnt_en, last_pix;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [7:0]              px, py;
    logic [2:0]              pv;
    logic [8:0]              xs, ys;

    sprite_pixel_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .col_o   (col),
        .row_o   (row),
        .last_o  (last_pix)
    );

    // Snapshot only while idle, so an erase pass replays exactly what the preceding draw used.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            vis_q <= '0;
        end else if (state_q == ST_IDLE && bus.load_coord) begin
            x_q   <= bus.x_bus;
            y_q   <= bus.y_bus;
            vis_q <= bus.vis_bus;
        end
    end

    assign px = x_q[8*idx_q +: 8];
    assign py = y_q[8*idx_q +: 8];
    assign pv = vis_q[3*idx_q +: 3];
    assign xs = {1'b0, px} + 9'(col);
    assign ys = {1'b0, py} + 9'(row);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.datapath_en) begin
                    op_d    = bus.op;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (pv != BLACK && op_is_valid(op_q)) begin
                    state_d = ST_PLOT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PLOT: begin
                cnt_en = 1'b1;
                if (last_pix) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Clip on the 9-bit sums so sprites near x=255 cannot wrap back on-screen.
    always_comb begin
        bus.x_out  = '0;
        bus.y_out  = '0;
        bus.colour = BLACK;
        bus.plot   = 1'b0;
        if (state_q == ST_PLOT) begin
            bus.x_out  = xs[7:0];
            bus.y_out  = ys[6:0];
            bus.colour = (op_q == OP_DRAW) ? pv : BLACK;
            bus.plot   = (xs < X_LIM) && (ys < Y_LIM);
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
endmodule
